// File: rtl/i2c_eng_if.sv
// Command/response port between the sequencer and the byte-level I2C master engine.
`timescale 1ns/1ps
interface i2c_eng_if;
    logic       eng_cmd_valid;
    logic       eng_cmd_ready;
    logic [1:0] eng_cmd;
    logic [7:0] eng_wdata;
    logic       eng_rd_nack;
    logic       eng_done;
    logic       eng_ack;
    logic [7:0] eng_rdata;

    modport master (
        output eng_cmd_valid, eng_cmd, eng_wdata, eng_rd_nack,
        input  eng_cmd_ready, eng_done, eng_ack, eng_rdata
    );
    modport slave (
        input  eng_cmd_valid, eng_cmd, eng_wdata, eng_rd_nack,
        output eng_cmd_ready, eng_done, eng_ack, eng_rdata
    );
endinterface

// File: rtl/i2c_seq_ctrl.sv
// I2C transaction sequencer: replays a register-init table as writes, then
// polls one status register every POLL_TICKS strobes.
`timescale 1ns/1ps
module i2c_seq_ctrl #(
    parameter logic [6:0]              SLAVE_ADDR = 7'd52,
    parameter int                      NUM_INIT   = 4,
    parameter logic [16*NUM_INIT-1:0]  INIT_TABLE = '0,
    parameter logic [7:0]              POLL_REG   = 8'h00,
    parameter logic [15:0]             POLL_TICKS = 16'd10000,
    parameter int                      MAX_RETRY  = 3
) (
    input  logic       clk_10MHz,
    input  logic       areset_n,
    input  logic       strobe_100kHz,
    input  logic       start,
    i2c_eng_if.master  bus,
    output logic       busy,
    output logic       init_done,
    output logic       error,
    output logic [7:0] rd_data,
    output logic       rd_valid
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_PWAIT = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;

    logic [2:0]  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        vld_q, vld_d;
    logic        wait_q, wait_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] tick_q, tick_d;
    logic        nack_q, nack_d;
    logic        busy_q, busy_d;
    logic        init_done_q, init_done_d;
    logic        error_q, error_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rbyte_q, rbyte_d;

    logic [1:0]  cur_cmd;
    logic [7:0]  cur_byte;
    logic        cur_nack;
    logic [15:0] entry;
    logic [2:0]  last_step;

    // Command for the current step; registered state/step keep it stable while not ready.
    always_comb begin
        cur_cmd  = C_START;
        cur_byte = 8'h00;
        cur_nack = 1'b0;
        entry    = 16'(INIT_TABLE >> {idx_q, 4'b0000});
        if (state_q == S_INIT) begin
            case (step_q)
                3'd0:    cur_cmd = C_START;
                3'd1:    begin cur_cmd = C_WRITE; cur_byte = {SLAVE_ADDR, 1'b0}; end
                3'd2:    begin cur_cmd = C_WRITE; cur_byte = entry[15:8]; end
                3'd3:    begin cur_cmd = C_WRITE; cur_byte = entry[7:0]; end
                default: cur_cmd = C_STOP;
            endcase
        end else begin
            case (step_q)
                3'd0:    cur_cmd = C_START;
                3'd1:    begin cur_cmd = C_WRITE; cur_byte = {SLAVE_ADDR, 1'b0}; end
                3'd2:    begin cur_cmd = C_WRITE; cur_byte = POLL_REG; end
                3'd3:    cur_cmd = C_START;
                3'd4:    begin cur_cmd = C_WRITE; cur_byte = {SLAVE_ADDR, 1'b1}; end
                3'd5:    begin cur_cmd = C_READ; cur_nack = 1'b1; end
                default: cur_cmd = C_STOP;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        vld_d       = vld_q;
        wait_d      = wait_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        tick_d      = tick_q;
        nack_d      = nack_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        error_d     = error_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rbyte_d     = rbyte_q;
        last_step   = (state_q == S_POLL) ? 3'd6 : 3'd4;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    step_d  = '0;
                    retry_d = '0;
                    nack_d  = 1'b0;
                    error_d = 1'b0;
                    vld_d   = 1'b1;
                end
            end
            S_PWAIT: begin
                if (strobe_100kHz) begin
                    if (tick_q == POLL_TICKS - 16'd1) begin
                        state_d = S_POLL;
                        step_d  = '0;
                        tick_d  = '0;
                        vld_d   = 1'b1;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
            end
            default: begin
                if (vld_q && bus.eng_cmd_ready) begin
                    vld_d  = 1'b0;
                    wait_d = 1'b1;
                    if (step_q == 3'd0) busy_d = 1'b1;
                end
                if (wait_q && bus.eng_done) begin
                    wait_d = 1'b0;
                    if (cur_cmd == C_STOP) begin
                        busy_d = 1'b0;
                        nack_d = 1'b0;
                        step_d = '0;
                        if (nack_q) begin
                            if (retry_q < 4'(MAX_RETRY)) begin
                                retry_d = retry_q + 4'd1;
                                vld_d   = 1'b1;
                            end else begin
                                error_d = 1'b1;
                                state_d = S_ERR;
                            end
                        end else begin
                            retry_d = '0;
                            if (state_q == S_POLL) begin
                                rd_data_d  = rbyte_q;
                                rd_valid_d = 1'b1;
                                state_d    = S_PWAIT;
                                tick_d     = '0;
                            end else begin
                                idx_d = idx_q + 5'd1;
                                if (idx_q == 5'(NUM_INIT - 1)) begin
                                    init_done_d = 1'b1;
                                    state_d     = S_PWAIT;
                                    tick_d      = '0;
                                end else begin
                                    vld_d = 1'b1;
                                end
                            end
                        end
                    end else if (cur_cmd == C_WRITE && !bus.eng_ack) begin
                        // Abandon remaining bytes; close the bus before retrying.
                        nack_d = 1'b1;
                        step_d = last_step;
                        vld_d  = 1'b1;
                    end else begin
                        if (cur_cmd == C_READ) rbyte_d = bus.eng_rdata;
                        step_d = step_q + 3'd1;
                        vld_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_10MHz or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            vld_q       <= 1'b0;
            wait_q      <= 1'b0;
            idx_q       <= '0;
            retry_q     <= '0;
            tick_q      <= '0;
            nack_q      <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rbyte_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            vld_q       <= vld_d;
            wait_q      <= wait_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            tick_q      <= tick_d;
            nack_q      <= nack_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rbyte_q     <= rbyte_d;
        end
    end

    // Payload is forced to zero when idle so reset leaves every output at 0.
    assign bus.eng_cmd_valid = vld_q;
    assign bus.eng_cmd       = vld_q ? cur_cmd  : 2'd0;
    assign bus.eng_wdata     = vld_q ? cur_byte : 8'h00;
    assign bus.eng_rd_nack   = vld_q & cur_nack;

    // Busy already in the cycle the first START is accepted.
    assign busy      = busy_q | (vld_q & bus.eng_cmd_ready & (step_q == 3'd0));
    assign init_done = init_done_q;
    assign error     = error_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Bench for i2c_seq_ctrl: engine model at the negedge, expected command queue,
// table of init scenarios plus hand-written poll/error/reset sequences.
`timescale 1ns/1ps
module tb_i2c_seq_ctrl;
    logic clk = 1'b0;
    logic areset_n = 1'b0;
    logic strobe = 1'b0;
    logic start = 1'b0;
    logic busy, init_done, error, rd_valid;
    logic [7:0] rd_data;

    i2c_eng_if bus();

    i2c_seq_ctrl #(
        .SLAVE_ADDR(7'd52), .NUM_INIT(2), .INIT_TABLE(32'h2BCD_1ABC),
        .POLL_REG(8'h0F), .POLL_TICKS(16'd2), .MAX_RETRY(3)
    ) dut (
        .clk_10MHz(clk), .areset_n(areset_n), .strobe_100kHz(strobe), .start(start),
        .bus(bus), .busy(busy), .init_done(init_done), .error(error),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // ---------------- engine model (owns all eng_* inputs) ----------------
    int          nack_cfg  = 0;
    int          ready_dly = 0;
    logic [7:0]  rdata_cfg = 8'h00;
    int          cyc = 0;
    int          act_n, nacks_given, last_stop_cyc, wait_cnt, pend_cnt;
    logic [10:0] act_arr [0:255];
    bit          act_ok  [0:255];
    bit          pend, holding, bad, early, first_wr;
    logic [10:0] held, cur_v;
    logic [1:0]  cur;

    always @(negedge clk or negedge areset_n) begin
        if (!areset_n) begin
            bus.eng_cmd_ready = 1'b0; bus.eng_done = 1'b0;
            bus.eng_ack = 1'b0; bus.eng_rdata = 8'h00;
            pend = 0; holding = 0; bad = 0; early = 0; first_wr = 0;
            act_n = 0; nacks_given = 0; last_stop_cyc = 0;
        end else begin
            cyc++;
            bus.eng_done = 1'b0;
            bus.eng_ack  = 1'b0;
            bus.eng_cmd_ready = 1'b0;
            cur_v = {bus.eng_cmd, bus.eng_wdata, bus.eng_rd_nack};
            if (pend) begin
                if (bus.eng_cmd_valid) early = 1;
                if (pend_cnt == 0) begin
                    pend = 0;
                    bus.eng_done = 1'b1;
                    case (cur)
                        2'd0: first_wr = 1;
                        2'd1: begin
                            bus.eng_ack = 1'b1;
                            if (first_wr) begin
                                first_wr = 0;
                                if (nacks_given < nack_cfg) begin
                                    nacks_given++;
                                    bus.eng_ack = 1'b0;
                                end
                            end
                        end
                        2'd2: bus.eng_rdata = rdata_cfg;
                        default: last_stop_cyc = cyc;
                    endcase
                end else pend_cnt--;
            end else if (bus.eng_cmd_valid) begin
                if (!holding) begin
                    holding = 1; held = cur_v; wait_cnt = ready_dly;
                end else if (cur_v != held) bad = 1;
                if (wait_cnt == 0) begin
                    bus.eng_cmd_ready = 1'b1;
                    act_arr[act_n] = cur_v;
                    act_ok[act_n]  = !bad && !early;
                    act_n++;
                    bad = 0; early = 0; holding = 0;
                    pend = 1; pend_cnt = 1; cur = bus.eng_cmd;
                end else wait_cnt--;
            end else if (holding) begin
                bad = 1; holding = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cmp_ptr  = 0;
    logic [10:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [10:0] ev(input logic [1:0] c, input logic [7:0] b, input logic n);
        return {c, b, n};
    endfunction

    function automatic logic [23:0] outs();
        return {bus.eng_cmd_valid, bus.eng_cmd, bus.eng_wdata, bus.eng_rd_nack,
                busy, init_done, error, rd_data, rd_valid};
    endfunction

    task automatic push_init(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back(ev(2'd0, 8'h00, 1'b0));
        exp_q.push_back(ev(2'd1, 8'h68, 1'b0));
        exp_q.push_back(ev(2'd1, r, 1'b0));
        exp_q.push_back(ev(2'd1, d, 1'b0));
        exp_q.push_back(ev(2'd3, 8'h00, 1'b0));
    endtask

    task automatic push_nack();
        exp_q.push_back(ev(2'd0, 8'h00, 1'b0));
        exp_q.push_back(ev(2'd1, 8'h68, 1'b0));
        exp_q.push_back(ev(2'd3, 8'h00, 1'b0));
    endtask

    task automatic push_poll();
        exp_q.push_back(ev(2'd0, 8'h00, 1'b0));
        exp_q.push_back(ev(2'd1, 8'h68, 1'b0));
        exp_q.push_back(ev(2'd1, 8'h0F, 1'b0));
        exp_q.push_back(ev(2'd0, 8'h00, 1'b0));
        exp_q.push_back(ev(2'd1, 8'h69, 1'b0));
        exp_q.push_back(ev(2'd2, 8'h00, 1'b1));
        exp_q.push_back(ev(2'd3, 8'h00, 1'b0));
    endtask

    // Pop one expectation per observed transfer.
    task automatic drain(input string name);
        logic [10:0] e;
        while (cmp_ptr < act_n) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
            chk({name, "_cmd"}, 32'(act_arr[cmp_ptr]), 32'(e));
            chk({name, "_proto"}, 32'(act_ok[cmp_ptr]), 32'd1);
            cmp_ptr++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_out", 32'(outs()), 32'd0);
        areset_n = 1'b1;
        exp_q.delete();
        cmp_ptr = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_strobe();
        @(negedge clk); #1 strobe = 1'b1;
        @(negedge clk); #1 strobe = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int c;
        for (c = 0; c < 3000; c++) begin
            if (init_done || error) break;
            @(negedge clk); #1;
        end
        chk({name, "_timeout"}, 32'(init_done | error), 32'd1);
        chk({name, "_lat"}, cyc - last_stop_cyc, 1);
    endtask

    task automatic wait_rdv(input string name);
        int c;
        for (c = 0; c < 2000; c++) begin
            if (rd_valid) break;
            @(negedge clk); #1;
        end
        chk({name, "_timeout"}, 32'(rd_valid), 32'd1);
        chk({name, "_lat"}, cyc - last_stop_cyc, 1);
    endtask

    typedef struct { int nack; int dly; bit err; int ncmd; } vec_t;
    vec_t vt [3];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        vt[0] = '{nack: 0, dly: 0, err: 1'b0, ncmd: 10};
        vt[1] = '{nack: 2, dly: 0, err: 1'b0, ncmd: 16};
        vt[2] = '{nack: 0, dly: 5, err: 1'b0, ncmd: 10};

        for (int i = 0; i < 3; i++) begin
            do_reset();
            nack_cfg = vt[i].nack; ready_dly = vt[i].dly;
            for (int k = 0; k < vt[i].nack; k++) push_nack();
            push_init(8'h1A, 8'hBC);
            push_init(8'h2B, 8'hCD);
            pulse_start();
            wait_end($sformatf("row%0d", i));
            chk($sformatf("row%0d_init_done", i), 32'(init_done), 32'(!vt[i].err));
            chk($sformatf("row%0d_error", i), 32'(error), 32'(vt[i].err));
            repeat (10) @(negedge clk); #1;
            chk($sformatf("row%0d_ncmd", i), act_n, vt[i].ncmd);
            drain($sformatf("row%0d", i));
        end
        ready_dly = 0;

        // Always NACK: four attempts then sticky error and silence.
        do_reset();
        nack_cfg = 1000;
        for (int k = 0; k < 4; k++) push_nack();
        pulse_start();
        wait_end("errseq");
        chk("errseq_error", 32'(error), 32'd1);
        chk("errseq_init_done", 32'(init_done), 32'd0);
        repeat (50) @(negedge clk); #1;
        chk("errseq_ncmd", act_n, 12);
        drain("errseq");

        // start from ERROR clears error and reruns entry 0.
        nack_cfg = 0;
        push_init(8'h1A, 8'hBC);
        push_init(8'h2B, 8'hCD);
        pulse_start();
        chk("recover_err_clr", 32'(error), 32'd0);
        wait_end("recover");
        chk("recover_init_done", 32'(init_done), 32'd1);
        chk("recover_error", 32'(error), 32'd0);
        drain("recover");

        // Poll every 2 strobes; one strobe alone must not trigger.
        rdata_cfg = 8'hA5;
        n0 = act_n;
        pulse_strobe();
        repeat (20) @(negedge clk); #1;
        chk("poll_one_strobe", act_n, n0);
        push_poll();
        pulse_strobe();
        wait_rdv("poll1");
        chk("poll1_data", 32'(rd_data), 32'hA5);
        @(negedge clk); #1;
        chk("poll1_rdv_pulse", 32'(rd_valid), 32'd0);
        chk("poll1_busy", 32'(busy), 32'd0);
        drain("poll1");

        rdata_cfg = 8'h3C;
        push_poll();
        pulse_strobe();
        pulse_strobe();
        wait_rdv("poll2");
        chk("poll2_data", 32'(rd_data), 32'h3C);
        drain("poll2");

        // Async reset during the third init WRITE.
        do_reset();
        pulse_start();
        for (int c = 0; c < 500; c++) begin
            if (act_n >= 4) break;
            @(negedge clk); #1;
        end
        chk("mid_reached", 32'(act_n >= 4), 32'd1);
        @(negedge clk); #1;
        chk("mid_busy", 32'(busy), 32'd1);
        #2 areset_n = 1'b0;
        #1 chk("mid_async_out", 32'(outs()), 32'd0);
        @(negedge clk); areset_n = 1'b1;
        repeat (30) @(negedge clk); #1;
        chk("mid_no_cmds", act_n, 0);
        chk("mid_quiet_out", 32'(outs()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
